// File: rtl/iob_reg_ce_pkg.sv
// Shared defaults for the iob_reg_ce clock-enabled register.
// Parity support is compiled in only when IOB_REG_PARITY_EN is defined.
package iob_reg_ce_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int MAX_DATA_W     = 1024;

endpackage : iob_reg_ce_pkg

// File: rtl/iob_parity_gen.sv
// Even-parity generator: XOR-reduce of a DATA_W-bit word.
// Present only when IOB_REG_PARITY_EN is defined.
`ifdef IOB_REG_PARITY_EN
module iob_parity_gen #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ^data;

endmodule : iob_parity_gen
`endif

// File: rtl/iob_reg_ce.sv
// Clock-enabled storage register with async reset (arst), sync clear (rst) and
// write enable (en). Optional even-parity bit under IOB_REG_PARITY_EN.
module iob_reg_ce
  import iob_reg_ce_pkg::*;
#(
  parameter int                DATA_W  = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
`ifdef IOB_REG_PARITY_EN
  output logic              parity_out,
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] data_out
);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the async reset branch is listed first to win over clk.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data_out <= RST_VAL;
    end else if (rst) begin
      data_out <= RST_VAL;
    end else if (en) begin
      data_out <= data_in;
    end
  end

`ifdef IOB_REG_PARITY_EN
  localparam logic RST_PARITY = ^RST_VAL;

  logic dataInParity;
  logic dataOutParity;

  iob_parity_gen #(.DATA_W(DATA_W)) inParityGen (
    .data   (data_in),
    .parity (dataInParity)
  );

  iob_parity_gen #(.DATA_W(DATA_W)) outParityGen (
    .data   (data_out),
    .parity (dataOutParity)
  );

  // Parity bit follows exactly the same reset/clear/enable rules as the data.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      parity_out <= RST_PARITY;
    end else if (rst) begin
      parity_out <= RST_PARITY;
    end else if (en) begin
      parity_out <= dataInParity;
    end
  end

  assign parity_err = parity_out ^ dataOutParity;
`endif

endmodule : iob_reg_ce

// File: tb/tb_iob_reg_ce.sv
// Self-checking bench for iob_reg_ce: table-driven vectors through a scoreboard
// queue plus hand-written async reset / tied reset sequences.
module tb_iob_reg_ce;

  localparam int          DATA_W  = 32;
  localparam logic [31:0] RST_VAL = 32'h0000_00A5;

  logic        clk;
  logic        arst;
  logic        rst;
  logic        en;
  logic [31:0] data_in;
  logic [31:0] data_out;
`ifdef IOB_REG_PARITY_EN
  logic        parity_out;
  logic        parity_err;
`endif

  iob_reg_ce #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) dut (
    .clk        (clk),
    .arst       (arst),
    .rst        (rst),
    .en         (en),
    .data_in    (data_in),
`ifdef IOB_REG_PARITY_EN
    .parity_out (parity_out),
    .parity_err (parity_err),
`endif
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  int  nChecks = 0;
  int  nFails  = 0;
  sb_t sbQueue[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one synchronous cycle at the falling edge and queue its expected result.
  task automatic drive(input logic r, input logic e, input logic [31:0] d,
                       input logic [31:0] exp, input string name);
    sb_t item;
    @(negedge clk);
    rst = r; en = e; data_in = d;
    item.exp = exp; item.name = name;
    sbQueue.push_back(item);
  endtask

  task automatic sample_after_edge();
    sb_t item;
    @(posedge clk);
    #1;
    if (sbQueue.size() == 0) begin
      nChecks++; nFails++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      item = sbQueue.pop_front();
      check(item.name, data_out, item.exp);
    end
  endtask

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, "write"};
    for (int i = 1; i <= 5; i++)
      vecs[i] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, "hold"};
    vecs[6]  = '{1'b0, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, "write_cafe"};
    vecs[7]  = '{1'b1, 1'b1, 32'h1111_1111, RST_VAL,       "clr_over_en"};
    vecs[8]  = '{1'b1, 1'b0, 32'h2222_2222, RST_VAL,       "clr_no_en"};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, "b2b_1"};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000_0002, "b2b_2"};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0003, "b2b_3"};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0003, "b2b_hold"};

    // Power-on reset: value appears without any clock edge.
    arst = 1'b1; rst = 1'b0; en = 1'b1; data_in = 32'hDEAD_BEEF;
    #1;
    check("por_async", data_out, RST_VAL);
`ifdef IOB_REG_PARITY_EN
    check("por_parity_err", {31'b0, parity_err}, 32'h0);
`endif
    @(posedge clk); #1;
    check("por_held", data_out, RST_VAL);
    @(negedge clk);
    arst = 1'b0; en = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].din, vecs[i].exp, vecs[i].name);
      sample_after_edge();
    end

    // arst mid-cycle with a pending write: cleared before the next edge, write lost.
    @(negedge clk);
    en = 1'b1; data_in = 32'hDEAD_BEEF;
    #2 arst = 1'b1;
    #1;
    check("arst_mid_async", data_out, RST_VAL);
    @(posedge clk); #1;
    check("arst_mid_held1", data_out, RST_VAL);
    @(posedge clk); #1;
    check("arst_mid_held2", data_out, RST_VAL);
    @(negedge clk);
    arst = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    check("arst_release_nowrite", data_out, RST_VAL);

    // Streaming writes with arst and rst tied together for two cycles.
    drive(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, "stream_a");
    sample_after_edge();
    @(negedge clk);
    arst = 1'b1; rst = 1'b1; en = 1'b1; data_in = 32'h0000_0011;
    #1;
    check("tied_async", data_out, RST_VAL);
    @(posedge clk); #1;
    check("tied_cyc1", data_out, RST_VAL);
    @(negedge clk);
    data_in = 32'h0000_0012;
    @(posedge clk); #1;
    check("tied_cyc2", data_out, RST_VAL);
    @(negedge clk);
    arst = 1'b0; rst = 1'b0; en = 1'b1; data_in = 32'h0000_0042;
    #1;
    check("tied_release_level", data_out, RST_VAL);
    @(posedge clk); #1;
    check("tied_first_write", data_out, 32'h0000_0042);

`ifdef IOB_REG_PARITY_EN
    drive(1'b0, 1'b1, 32'h0000_0007, 32'h0000_0007, "par_write7");
    sample_after_edge();
    check("par7_out", {31'b0, parity_out}, 32'h1);
    check("par7_err", {31'b0, parity_err}, 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0003, 32'h0000_0003, "par_write3");
    sample_after_edge();
    check("par3_out", {31'b0, parity_out}, 32'h0);
    check("par3_err", {31'b0, parity_err}, 32'h0);
    @(negedge clk);
    en = 1'b0;
    force dut.data_out = 32'h0000_0002;
    #1;
    check("par_forced_err", {31'b0, parity_err}, 32'h1);
    release dut.data_out;
    @(negedge clk);
    arst = 1'b1;
    #1;
    check("par_rst_err", {31'b0, parity_err}, 32'h0);
    arst = 1'b0;
`endif

    if (sbQueue.size() != 0) begin
      nChecks++; nFails++;
      $display("FAIL scoreboard_leftover: %0d entries remain", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_iob_reg_ce
